// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one block from pipelined main memory word by word,
// streams each returned word into the data array, then writes the tag array.
module cache_fill_fsm #(
   parameter int unsigned WORDS_PER_BLOCK = 8,
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned DATA_W          = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               miss_detected,
   input  logic [ADDR_W-1:0]                  miss_address,
   output logic                               fsm_busy,
   output logic                               memory_req,
   output logic [ADDR_W-1:0]                  memory_address,
   input  logic                               memory_data_valid,
   input  logic [DATA_W-1:0]                  memory_data,
   output logic                               write_data_array,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_offset,
   output logic [DATA_W-1:0]                  fill_data,
   output logic                               write_tag_array,
   output logic [ADDR_W-1:0]                  fill_block_addr
);

   localparam int unsigned OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned CNT_W = OFF_W + 1;
   // Block spans 2*WORDS_PER_BLOCK bytes; clear the byte-in-block bits.
   localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_req_cnt;
   logic [CNT_W-1:0]  w_req_cnt_nxt;
   logic [CNT_W-1:0]  r_ret_cnt;
   logic [CNT_W-1:0]  w_ret_cnt_nxt;
   logic [ADDR_W-1:0] r_block_addr;
   logic [ADDR_W-1:0] w_block_addr_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_req_cnt    <= '0;
         r_ret_cnt    <= '0;
         r_block_addr <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_req_cnt    <= w_req_cnt_nxt;
         r_ret_cnt    <= w_ret_cnt_nxt;
         r_block_addr <= w_block_addr_nxt;
      end
   end

   // Requests and returns are tracked independently so any memory latency works.
   always_comb begin
      w_state_nxt      = r_state;
      w_req_cnt_nxt    = r_req_cnt;
      w_ret_cnt_nxt    = r_ret_cnt;
      w_block_addr_nxt = r_block_addr;
      fsm_busy         = 1'b0;
      memory_req       = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      fill_word_offset = '0;
      fill_data        = '0;
      write_tag_array  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (miss_detected) begin
               w_state_nxt      = S_FILL;
               w_block_addr_nxt = miss_address & BLK_MASK;
               w_req_cnt_nxt    = '0;
               w_ret_cnt_nxt    = '0;
            end
         end
         S_FILL: begin
            fsm_busy = 1'b1;
            if (r_req_cnt < CNT_W'(WORDS_PER_BLOCK)) begin
               memory_req     = 1'b1;
               memory_address = r_block_addr + ADDR_W'({r_req_cnt, 1'b0});
               w_req_cnt_nxt  = r_req_cnt + CNT_W'(1);
            end
            write_data_array = memory_data_valid;
            fill_word_offset = r_ret_cnt[OFF_W-1:0];
            fill_data        = memory_data;
            if (memory_data_valid) begin
               w_ret_cnt_nxt = r_ret_cnt + CNT_W'(1);
               if (r_ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
                  write_tag_array = 1'b1;
                  w_state_nxt     = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign fill_block_addr = r_block_addr;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a memory model answers requests, a
// transaction-level model predicts busy, request stream and data/tag writes.
module tb_cache_fill_fsm;

   localparam int unsigned WPB = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        fsm_busy;
   logic        memory_req;
   logic [15:0] memory_address;
   logic        memory_data_valid;
   logic [15:0] memory_data;
   logic        write_data_array;
   logic [2:0]  fill_word_offset;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic [15:0] fill_block_addr;

   cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .miss_detected(miss_detected), .miss_address(miss_address),
      .fsm_busy(fsm_busy), .memory_req(memory_req), .memory_address(memory_address),
      .memory_data_valid(memory_data_valid), .memory_data(memory_data),
      .write_data_array(write_data_array), .fill_word_offset(fill_word_offset),
      .fill_data(fill_data), .write_tag_array(write_tag_array),
      .fill_block_addr(fill_block_addr)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] addr; int cyc; } req_t;
   typedef struct { logic [2:0] off; logic [15:0] data; logic tag; logic [15:0] blk; int cyc; } wr_t;
   typedef struct { int t; logic [15:0] data; } ret_t;

   req_t req_q[$];
   wr_t  wr_q[$];
   ret_t ret_q[$];

   int          cyc = 0;
   bit          m_busy = 1'b0;
   int          m_ret = 0;
   int          m_fills = 0;
   logic [15:0] m_blk = '0;
   int          mem_mode = 0;   // 0: 4-cycle random data, 1: gapped random data, 2: 4-cycle 0xA000+offset
   int          last_t = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          busy_run = 0;
   int          busy_len = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model of fill progress plus memory return driver.
   always @(posedge clk) begin
      wr_t w;
      ret_t r;
      cyc++;
      if (!rst_n) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         if (memory_data_valid) begin
            m_ret++;
            if (m_ret == WPB) m_busy = 1'b0;
         end
      end else if (miss_detected) begin
         m_busy = 1'b1;
         m_ret  = 0;
         m_fills++;
         m_blk  = miss_address & 16'hFFF0;
         for (int i = 0; i < WPB; i++)
            req_q.push_back('{addr: m_blk + 16'(2 * i), cyc: cyc + i});
      end
      #1;
      memory_data_valid = 1'b0;
      memory_data       = '0;
      if (ret_q.size() > 0 && ret_q[0].t == cyc) begin
         r = ret_q.pop_front();
         memory_data_valid = 1'b1;
         memory_data       = r.data;
         if (m_busy && rst_n) begin
            w.off  = 3'(m_ret);
            w.data = (mem_mode == 2) ? 16'hA000 + 16'(m_ret) : r.data;
            w.tag  = (m_ret == WPB - 1);
            w.blk  = m_blk;
            w.cyc  = cyc;
            wr_q.push_back(w);
         end
      end
   end

   // Monitor: compares DUT activity against the scoreboard; also schedules memory returns.
   always @(negedge clk) begin
      req_t e;
      wr_t  w;
      int   t;
      chk("busy", 32'(fsm_busy), 32'(m_busy));
      if (memory_req) begin
         if (req_q.size() == 0) chk("req_unexpected", 32'(memory_req), 32'd0);
         else begin
            e = req_q.pop_front();
            chk("req_addr", 32'(memory_address), 32'(e.addr));
            chk("req_cycle", 32'(cyc), 32'(e.cyc));
         end
         if (mem_mode == 1) begin
            t = last_t + int'($urandom_range(1, 3));
            if (t < cyc + 1) t = cyc + 1;
         end else t = cyc + 4;
         last_t = t;
         ret_q.push_back('{t: t, data: (mem_mode == 2) ? 16'hA000 + 16'(memory_address[3:1])
                                                      : 16'($urandom)});
      end
      if (write_data_array) begin
         if (wr_q.size() == 0) chk("wr_unexpected", 32'(write_data_array), 32'd0);
         else begin
            w = wr_q.pop_front();
            chk("wr_offset", 32'(fill_word_offset), 32'(w.off));
            chk("wr_data", 32'(fill_data), 32'(w.data));
            chk("wr_tag", 32'(write_tag_array), 32'(w.tag));
            chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            if (w.tag) chk("tag_block", 32'(fill_block_addr), 32'(w.blk));
         end
      end else if (write_tag_array) begin
         chk("tag_alone", 32'(write_tag_array), 32'd0);
      end
      if (fsm_busy) busy_run++;
      else begin
         if (busy_run > 0) busy_len = busy_run;
         busy_run = 0;
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ctrl"}, 32'({fsm_busy, memory_req, write_data_array, write_tag_array}), 32'd0);
      chk({tag, "_addr"}, 32'(memory_address), 32'd0);
      chk({tag, "_fill"}, 32'({fill_word_offset, fill_data}), 32'd0);
      chk({tag, "_blk"}, 32'(fill_block_addr), 32'd0);
   endtask

   task automatic issue_miss(input logic [15:0] a);
      @(posedge clk); #1;
      miss_detected = 1'b1;
      miss_address  = a;
      @(posedge clk); #1;
      miss_detected = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = !m_busy && req_q.size() == 0 && wr_q.size() == 0 && ret_q.size() == 0;
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s_timeout: busy=%0d reqs=%0d wrs=%0d rets=%0d left",
                  name, m_busy, req_q.size(), wr_q.size(), ret_q.size());
         req_q.delete(); wr_q.delete(); ret_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int f0;
      rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
      memory_data_valid = 1'b0; memory_data = '0;
      repeat (3) @(posedge clk);
      #1 check_idle_outputs("reset");
      rst_n = 1'b1;

      // Aligned 4-cycle memory, data-integrity pattern.
      mem_mode = 2; busy_len = 0;
      issue_miss(16'h1236);
      wait_done("fill_4cyc");
      chk("busy_len", 32'(busy_len), 32'd12);

      // Gapped returns.
      mem_mode = 1;
      issue_miss(16'h2468);
      wait_done("fill_gapped");

      // Miss toggling during FILL is ignored.
      mem_mode = 0;
      issue_miss(16'h1236);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         miss_detected = i[0];
         miss_address  = 16'h4000;
      end
      miss_detected = 1'b0;
      wait_done("fill_toggle");
      chk("blk_after_toggle", 32'(fill_block_addr), 32'h1230);

      // Reset after 3 returns, trailing valids, then fresh miss at top of memory.
      mem_mode = 0;
      issue_miss(16'h5550);
      for (int i = 0; i < 100 && m_ret < 3; i++) @(negedge clk);
      @(posedge clk); #3;
      rst_n = 1'b0;
      req_q.delete(); wr_q.delete(); m_busy = 1'b0;
      #1 check_idle_outputs("mid_reset");
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_done("trailing");
      issue_miss(16'hFFF2);
      wait_done("fill_wrap");

      // Back-to-back with miss held high.
      mem_mode = 1;
      f0 = m_fills;
      @(posedge clk); #1;
      miss_detected = 1'b1;
      miss_address  = 16'h0A0A;
      for (int i = 0; i < 100 && m_fills < f0 + 1; i++) @(negedge clk);
      @(posedge clk); #1 miss_address = 16'h0B0B;
      for (int i = 0; i < 100 && m_fills < f0 + 2; i++) @(negedge clk);
      @(posedge clk); #1 miss_detected = 1'b0;
      wait_done("back_to_back");
      chk("b2b_fills", 32'(m_fills - f0), 32'd2);
      chk("b2b_blk", 32'(fill_block_addr), 32'h0B00);

      // Randomized fills.
      for (int k = 0; k < 8; k++) begin
         mem_mode = int'($urandom_range(0, 2));
         issue_miss(16'($urandom));
         wait_done("rand_fill");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
